// File: rtl/pmem_fetch.sv
// -----------------------------------------------------------------------------
// pmem_fetch
//   Program memory with an integrated fetch unit (PC register, increment,
//   branch select). A host loads program words through the ld_* side port
//   while the unit is IDLE or HALT. In RUN the unit streams one registered
//   instruction per cycle to the decode stage, honouring decoder stall,
//   branch redirect and a halt-on-word terminator.
//
//   Optional feature macro: PMEM_PARITY_EN
//     defined   : each array word carries an even-parity bit written at load
//                 and checked at fetch; a mismatch suppresses instr_vld, sets
//                 the sticky par_err flag and moves the FSM to HALT.
//     undefined : plain IW-bit array, par_err tied to 0.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   ld_en      in   1   load strobe, writes ld_instr to ld_addr
//   ld_addr    in   AW  load address
//   ld_instr   in   IW  load data
//   ld_err     out  1   1-cycle pulse: ld_en sampled while in RUN
//   run        in   1   start fetching from RESET_PC
//   stall      in   1   decoder back-pressure, hold current output
//   br_taken   in   1   redirect fetch to br_target
//   br_target  in   AW  branch destination
//   instr      out  IW  fetched instruction, registered
//   instr_pc   out  AW  address of instr
//   instr_vld  out  1   instr/instr_pc valid this cycle
//   pc         out  AW  address being fetched next
//   busy       out  1   FSM in RUN
//   halted     out  1   FSM in HALT
//   par_err    out  1   sticky parity error (0 unless PMEM_PARITY_EN)
// -----------------------------------------------------------------------------
module pmem_fetch #(
  parameter int              IW        = 12,
  parameter int              AW        = 8,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [IW-1:0]   HALT_WORD = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_instr,
  output logic          ld_err,
  input  logic          run,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_vld,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          par_err
);

  localparam int DEPTH = 1 << AW;
`ifdef PMEM_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc_next;
  logic [IW-1:0] instr_next;
  logic [AW-1:0] instr_pc_next;
  logic          vld_next;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;
  logic [IW-1:0] rd_data;
  logic          rd_bad;
  logic          ld_write;

  // Loading is only allowed while not fetching, so a write and a fetch never
  // touch the array in the same cycle.
  assign ld_write = ld_en && (state != S_RUN);

  // Word at the current pc; the halt compare needs it before the edge that
  // registers it, so the array is read combinationally and captured in instr.
  assign rd_word = mem[pc];
  assign rd_data = rd_word[IW-1:0];

`ifdef PMEM_PARITY_EN
  // Stored bit makes the total number of ones even.
  assign wr_word = {^ld_instr, ld_instr};
  assign rd_bad  = ^rd_word;
`else
  assign wr_word = ld_instr;
  assign rd_bad  = 1'b0;
`endif

  // NOTE: the program array has no reset; its contents must survive rst_n and
  // a reset term would also prevent mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (ld_write) begin
      mem[ld_addr] <= wr_word;
    end
  end

  // Next-state and datapath decisions.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise this block would infer latches.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    vld_next      = instr_vld;

    case (state)
      S_IDLE, S_HALT: begin
        vld_next = 1'b0;
        if (run) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
        end
      end

      S_RUN: begin
        if (br_taken) begin
          // The word fetched this cycle belongs to the wrong path: drop it.
          pc_next  = br_target;
          vld_next = 1'b0;
        end else if (stall) begin
          // Hold everything for the decoder.
        end else if (rd_bad) begin
          vld_next   = 1'b0;
          state_next = S_HALT;
        end else begin
          instr_next    = rd_data;
          instr_pc_next = pc;
          vld_next      = 1'b1;
          pc_next       = pc + AW'(1);
          if (rd_data == HALT_WORD) begin
            state_next = S_HALT;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        vld_next   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      instr_pc  <= '0;
      instr_vld <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      instr     <= instr_next;
      instr_pc  <= instr_pc_next;
      instr_vld <= vld_next;
      ld_err    <= ld_en && (state == S_RUN);
    end
  end

`ifdef PMEM_PARITY_EN
  logic par_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_flag <= 1'b0;
    end else if ((state == S_RUN) && !br_taken && !stall && rd_bad) begin
      par_flag <= 1'b1;
    end
  end

  assign par_err = par_flag;
`else
  assign par_err = 1'b0;
`endif

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_pmem_fetch.sv
// -----------------------------------------------------------------------------
// tb_pmem_fetch
//   Self-checking bench for pmem_fetch (IW=12, AW=8, RESET_PC=0,
//   HALT_WORD=0xFFF). A behavioural model (array + run/halt flags) predicts
//   every output after each clock edge; a directed table, hand-written
//   corner sequences and a randomized phase drive the DUT.
// -----------------------------------------------------------------------------
module tb_pmem_fetch;

  localparam int IW = 12;
  localparam int AW = 8;
  localparam logic [IW-1:0] HALT_W = 12'hFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_instr;
  logic          ld_err;
  logic          run;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_vld;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          par_err;

  pmem_fetch #(.IW(IW), .AW(AW), .RESET_PC(8'h00), .HALT_WORD(HALT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_instr  (ld_instr),
    .ld_err    (ld_err),
    .run       (run),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .instr_vld (instr_vld),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------------------
  logic [IW-1:0] m_mem [256];
  bit            m_running;
  bit            m_halted;
  int            m_pc;
  logic [IW-1:0] m_instr;
  int            m_ipc;
  bit            m_vld;
  bit            m_lderr;

  function automatic void model_reset();
    m_running = 0;
    m_halted  = 0;
    m_pc      = 0;
    m_instr   = '0;
    m_ipc     = 0;
    m_vld     = 0;
    m_lderr   = 0;
  endfunction

  // One clock edge worth of behaviour, from the current input values.
  function automatic void model_step();
    logic [IW-1:0] w;
    m_lderr = ld_en && m_running;
    if (!m_running) begin
      if (ld_en) m_mem[ld_addr] = ld_instr;
      m_vld = 0;
      if (run) begin
        m_running = 1;
        m_halted  = 0;
        m_pc      = 0;
      end
    end else if (br_taken) begin
      m_pc  = int'(br_target);
      m_vld = 0;
    end else if (!stall) begin
      w       = m_mem[m_pc];
      m_instr = w;
      m_ipc   = m_pc;
      m_vld   = 1;
      m_pc    = (m_pc + 1) % 256;
      if (w == HALT_W) begin
        m_running = 0;
        m_halted  = 1;
      end
    end
  endfunction

  task automatic check_all();
    check("instr_vld", 32'(instr_vld), 32'(m_vld));
    check("instr",     32'(instr),     32'(m_instr));
    check("instr_pc",  32'(instr_pc),  32'(m_ipc));
    check("pc",        32'(pc),        32'(m_pc));
    check("busy",      32'(busy),      32'(m_running));
    check("halted",    32'(halted),    32'(m_halted));
    check("ld_err",    32'(ld_err),    32'(m_lderr));
    check("par_err",   32'(par_err),   32'd0);
  endtask

  task automatic idle_inputs();
    ld_en = 0; ld_addr = '0; ld_instr = '0;
    run = 0; stall = 0; br_taken = 0; br_target = '0;
  endtask

  // Predict, clock, then compare 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    idle_inputs();
    ld_en = 1; ld_addr = a; ld_instr = d;
    cycle();
    idle_inputs();
  endtask

  // ---------------- directed table ----------------------------------------
  typedef struct {
    logic          ld;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
    logic          run;
    logic          stall;
    logic          br;
    logic [AW-1:0] tgt;
    logic          e_vld;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_ipc;
    logic [AW-1:0] e_pc;
    logic          e_busy;
    logic          e_halt;
  } vec_t;

  vec_t tbl [22];

  initial begin
    // ld addr data   run stl br tgt | vld instr ipc pc busy halt
    tbl[0]  = '{1, 8'h00, 12'h101, 0, 0, 0, 8'h00, 0, 12'h000, 8'h00, 8'h00, 0, 0};
    tbl[1]  = '{1, 8'h01, 12'h202, 0, 0, 0, 8'h00, 0, 12'h000, 8'h00, 8'h00, 0, 0};
    tbl[2]  = '{1, 8'h02, 12'hFFF, 0, 0, 0, 8'h00, 0, 12'h000, 8'h00, 8'h00, 0, 0};
    tbl[3]  = '{1, 8'h80, 12'h3C5, 0, 0, 0, 8'h00, 0, 12'h000, 8'h00, 8'h00, 0, 0};
    tbl[4]  = '{0, 8'h00, 12'h000, 1, 0, 0, 8'h00, 0, 12'h000, 8'h00, 8'h00, 1, 0};
    tbl[5]  = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h101, 8'h00, 8'h01, 1, 0};
    tbl[6]  = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[7]  = '{0, 8'h00, 12'h000, 0, 1, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[8]  = '{0, 8'h00, 12'h000, 0, 1, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[9]  = '{0, 8'h00, 12'h000, 0, 1, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[10] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'hFFF, 8'h02, 8'h03, 0, 1};
    tbl[11] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 0, 12'hFFF, 8'h02, 8'h03, 0, 1};
    tbl[12] = '{0, 8'h00, 12'h000, 1, 0, 0, 8'h00, 0, 12'hFFF, 8'h02, 8'h00, 1, 0};
    tbl[13] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h101, 8'h00, 8'h01, 1, 0};
    tbl[14] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[15] = '{0, 8'h00, 12'h000, 0, 0, 1, 8'h80, 0, 12'h202, 8'h01, 8'h80, 1, 0};
    tbl[16] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h3C5, 8'h80, 8'h81, 1, 0};
    tbl[17] = '{0, 8'h00, 12'h000, 0, 1, 1, 8'h00, 0, 12'h3C5, 8'h80, 8'h00, 1, 0};
    tbl[18] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h101, 8'h00, 8'h01, 1, 0};
    tbl[19] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'h202, 8'h01, 8'h02, 1, 0};
    tbl[20] = '{0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 1, 12'hFFF, 8'h02, 8'h03, 0, 1};
    tbl[21] = '{0, 8'h00, 12'h000, 0, 1, 1, 8'h40, 0, 12'hFFF, 8'h02, 8'h03, 0, 1};
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1;
    @(posedge clk);
    #1;

    // Fill the whole array so every later fetch has a known model value.
    for (int a = 0; a < 256; a++) begin
      do_load(AW'(a), IW'($urandom_range(0, 12'hFFE)));
    end

    // Directed table: load, run, stall, halt, branch, branch-beats-stall.
    for (int i = 0; i < 22; i++) begin
      ld_en = tbl[i].ld; ld_addr = tbl[i].addr; ld_instr = tbl[i].data;
      run = tbl[i].run; stall = tbl[i].stall;
      br_taken = tbl[i].br; br_target = tbl[i].tgt;
      cycle();
      check($sformatf("tbl%0d_vld", i),    32'(instr_vld), 32'(tbl[i].e_vld));
      check($sformatf("tbl%0d_instr", i),  32'(instr),     32'(tbl[i].e_instr));
      check($sformatf("tbl%0d_ipc", i),    32'(instr_pc),  32'(tbl[i].e_ipc));
      check($sformatf("tbl%0d_pc", i),     32'(pc),        32'(tbl[i].e_pc));
      check($sformatf("tbl%0d_busy", i),   32'(busy),      32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_halted", i), 32'(halted),    32'(tbl[i].e_halt));
    end
    idle_inputs();

    // Wrap 0xFF -> 0x00, with the run cycle also writing mem[0] (write-first).
    do_load(8'hFF, 12'h001);
    do_load(8'h01, HALT_W);
    ld_en = 1; ld_addr = 8'h00; ld_instr = 12'h002; run = 1;
    cycle();
    idle_inputs();
    br_taken = 1; br_target = 8'hFF;
    cycle();
    check("wrap_br_pc", 32'(pc), 32'h0FF);
    idle_inputs();
    cycle();
    check("wrap_ipc_ff", 32'(instr_pc), 32'h0FF);
    check("wrap_instr_ff", 32'(instr), 32'h001);
    check("wrap_pc_0", 32'(pc), 32'h000);
    cycle();
    check("wrap_ipc_00", 32'(instr_pc), 32'h000);
    check("write_first", 32'(instr), 32'h002);
    cycle();
    check("wrap_halt", 32'(halted), 32'h1);

    // Load guard: ld_en in RUN is refused and flagged for one cycle.
    do_load(8'h05, 12'h055);
    run = 1;
    cycle();
    idle_inputs();
    stall = 1; ld_en = 1; ld_addr = 8'h05; ld_instr = 12'h123;
    cycle();
    check("ld_err_pulse", 32'(ld_err), 32'h1);
    ld_en = 0;
    cycle();
    check("ld_err_clear", 32'(ld_err), 32'h0);
    idle_inputs();
    br_taken = 1; br_target = 8'h05;
    cycle();
    idle_inputs();
    cycle();
    check("guard_mem5", 32'(instr), 32'h055);
    check("guard_ipc5", 32'(instr_pc), 32'h005);

    // Asynchronous reset while in RUN, then re-run the surviving program.
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_busy", 32'(busy), 32'h0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    run = 1;
    cycle();
    run = 0;
    cycle();
    check("rerun_instr", 32'(instr), 32'h002);
    check("rerun_ipc", 32'(instr_pc), 32'h000);

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      ld_en     = ($urandom_range(0, 99) < 20);
      ld_addr   = AW'($urandom);
      ld_instr  = IW'($urandom);
      run       = ($urandom_range(0, 99) < 6);
      stall     = ($urandom_range(0, 99) < 25);
      br_taken  = ($urandom_range(0, 99) < 10);
      br_target = AW'($urandom);
      cycle();
    end
    idle_inputs();

`ifdef PMEM_PARITY_EN
    // Corrupt the stored word at address 1: it must never be presented.
    rst_n = 0;
    #3;
    rst_n = 1;
    @(posedge clk);
    #1;
    ld_en = 1; ld_addr = 8'h00; ld_instr = 12'h101;
    @(posedge clk); #1;
    ld_addr = 8'h01; ld_instr = 12'h202;
    @(posedge clk); #1;
    idle_inputs();
    dut.mem[1] = dut.mem[1] ^ 13'h001;
    run = 1;
    @(posedge clk); #1;
    run = 0;
    @(posedge clk); #1;
    check("par_first_ok", 32'(instr), 32'h101);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("par_no_202", 32'(instr_vld && (instr == 12'h202)), 32'h0);
    end
    check("par_err_set", 32'(par_err), 32'h1);
    check("par_halted", 32'(halted), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
